// File: rtl/nf10_axis_rec_pkg.sv
// Shared constants and types for the AXI4-Stream packet recorder.
package nf10_axis_rec_pkg;

   // tready policies
   localparam int unsigned BP_ALWAYS = 0;
   localparam int unsigned BP_LFSR   = 1;
   localparam int unsigned BP_FULL   = 2;

   // Record field widths; packing order is {err, tag, len}
   localparam int unsigned REC_LEN_W = 16;
   localparam int unsigned REC_TAG_W = 16;
   localparam int unsigned REC_ERR_W = 1;
   localparam int unsigned REC_W     = REC_ERR_W + REC_TAG_W + REC_LEN_W;

   // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   typedef struct packed {
      logic                 err;
      logic [REC_TAG_W-1:0] tag;
      logic [REC_LEN_W-1:0] len;
   } rec_t;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } rec_state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/nf10_axis_rec_fifo.sv
// Synchronous first-word-fall-through FIFO holding packet records.
module nf10_axis_rec_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_rd;
   logic             do_wr;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign do_rd     = rd_en_i & ~empty_o;
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands
   assign do_wr     = wr_en_i & (~full_o | do_rd);
   assign rd_data_o = mem_q[rd_ptr_q];

   // Storage array, written on accepted pushes
   always_ff @(posedge clk_i) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/nf10_axis_pkt_recorder.sv
// AXI4-Stream packet sink: counts beats/packets, checks strobes and records
// a {err, tag, len} summary per packet into a FWFT record FIFO.
module nf10_axis_pkt_recorder
   import nf10_axis_rec_pkg::*;
#(
   parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned C_REC_DEPTH          = 16,
   parameter int unsigned C_BP_MODE            = 0,
   parameter logic [15:0] C_LFSR_SEED          = 16'hACE1
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [7:0]                        counter,
   output logic                              activity_rec,
   output logic [31:0]                       pkt_count,
   output logic                              overflow,
   output logic                              rec_valid,
   input  logic                              rec_rd_en,
   output logic [15:0]                       rec_len,
   output logic [15:0]                       rec_tag,
   output logic                              rec_err
);

   localparam int unsigned STRB_W = C_S_AXIS_DATA_WIDTH / 8;

   function automatic logic [15:0] popcount(input logic [STRB_W-1:0] v);
      logic [15:0] c;
      c = '0;
      for (int unsigned i = 0; i < STRB_W; i++) begin
         c = c + {15'b0, v[i]};
      end
      return c;
   endfunction

   // True when v is of the form 0..01..1 (includes zero, excluded separately)
   function automatic logic contiguous(input logic [STRB_W-1:0] v);
      return ((v & (v + STRB_W'(1))) == '0);
   endfunction

   rec_state_t  state_q;
   logic [15:0] len_q, len_d;
   logic [15:0] tag_q, tag_d;
   logic        err_q, err_d;
   logic [15:0] strb_pc;
   logic [16:0] len_sum;
   logic        first_beat;
   logic        beat_err;
   logic        beat_acc;
   logic        push;
   rec_t        push_rec;
   rec_t        head;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  counter_q;
   logic [31:0] pkt_count_q;
   logic        overflow_q;
   logic        activity_q;
   logic        rdy_en_q;
   logic [15:0] lfsr_q;
   logic        lfsr_rdy_q;
   logic        unused_ok;

   assign unused_ok = ^{s_axis_tdata, s_axis_tuser};

   assign s_axis_tready = (C_BP_MODE == BP_LFSR) ? lfsr_rdy_q :
                          (C_BP_MODE == BP_FULL) ? (rdy_en_q & ~fifo_full) :
                                                   rdy_en_q;
   assign beat_acc = s_axis_tvalid & s_axis_tready;
   assign push     = beat_acc & s_axis_tlast;

   // Per-beat length/tag/error next-state, folding in the current beat
   always_comb begin
      first_beat = (state_q == ST_IDLE);
      strb_pc    = popcount(s_axis_tstrb);
      len_sum    = {1'b0, len_q} + {1'b0, strb_pc};
      if (s_axis_tlast) begin
         beat_err = (s_axis_tstrb == '0) | ~contiguous(s_axis_tstrb);
      end else begin
         beat_err = (s_axis_tstrb != '1);
      end
      len_d = first_beat ? strb_pc : (len_sum[16] ? 16'hFFFF : len_sum[15:0]);
      tag_d = first_beat ? s_axis_tuser[15:0] : tag_q;
      err_d = (first_beat ? 1'b0 : err_q) | beat_err;
      push_rec = '{err: err_d, tag: tag_d, len: len_d};
   end

   // Packet FSM with registered accumulator, tag and error flag
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         tag_q   <= '0;
         err_q   <= 1'b0;
      end else if (beat_acc) begin
         state_q <= s_axis_tlast ? ST_IDLE : ST_IN_PKT;
         len_q   <= len_d;
         tag_q   <= tag_d;
         err_q   <= err_d;
      end
   end

   // Packet counters, drop flag and beat activity pulse
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         counter_q   <= '0;
         pkt_count_q <= '0;
         overflow_q  <= 1'b0;
         activity_q  <= 1'b0;
      end else begin
         activity_q <= beat_acc;
         if (push) begin
            counter_q <= counter_q + 8'd1;
            if (pkt_count_q != 32'hFFFF_FFFF) pkt_count_q <= pkt_count_q + 32'd1;
            if (fifo_full & ~rec_rd_en) overflow_q <= 1'b1;
         end
      end
   end

   // Backpressure sources: out-of-reset enable and free-running LFSR
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rdy_en_q   <= 1'b0;
         lfsr_q     <= C_LFSR_SEED;
         lfsr_rdy_q <= 1'b0;
      end else begin
         rdy_en_q   <= 1'b1;
         lfsr_q     <= lfsr_next(lfsr_q);
         lfsr_rdy_q <= lfsr_q[0];
      end
   end

   nf10_axis_rec_fifo #(
      .WIDTH (REC_W),
      .DEPTH (C_REC_DEPTH)
   ) u_fifo (
      .clk_i     (aclk),
      .rst_i     (areset),
      .wr_en_i   (push),
      .wr_data_i (push_rec),
      .rd_en_i   (rec_rd_en),
      .rd_data_o (head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign counter      = counter_q;
   assign pkt_count    = pkt_count_q;
   assign overflow     = overflow_q;
   assign activity_rec = activity_q;
   assign rec_valid    = ~fifo_empty;
   assign rec_len      = fifo_empty ? '0   : head.len;
   assign rec_tag      = fifo_empty ? '0   : head.tag;
   assign rec_err      = fifo_empty ? 1'b0 : head.err;

endmodule

// File: tb/tb_nf10_axis_pkt_recorder.sv
// Directed bench: three recorder instances (mode 0 depth 16, mode 1, mode 2 depth 2).
module tb_nf10_axis_pkt_recorder;

   localparam int LIM = 200;

   logic aclk   = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   logic [255:0] tdata [3];
   logic [31:0]  tstrb [3];
   logic [127:0] tuser [3];
   logic [2:0]   tvalid, tlast, rd_en;
   logic [2:0]   tready, act, ovf, rvalid, rerr;
   logic [7:0]   cnt  [3];
   logic [31:0]  pcnt [3];
   logic [15:0]  rlen [3];
   logic [15:0]  rtag [3];

   int n_chk   = 0;
   int n_fail  = 0;
   int act_cnt = 0;

   nf10_axis_pkt_recorder #(.C_REC_DEPTH(16), .C_BP_MODE(0)) u0 (
      .aclk(aclk), .areset(areset), .s_axis_tdata(tdata[0]), .s_axis_tstrb(tstrb[0]),
      .s_axis_tuser(tuser[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
      .s_axis_tlast(tlast[0]), .counter(cnt[0]), .activity_rec(act[0]), .pkt_count(pcnt[0]),
      .overflow(ovf[0]), .rec_valid(rvalid[0]), .rec_rd_en(rd_en[0]), .rec_len(rlen[0]),
      .rec_tag(rtag[0]), .rec_err(rerr[0]));

   nf10_axis_pkt_recorder #(.C_REC_DEPTH(16), .C_BP_MODE(1), .C_LFSR_SEED(16'hACE1)) u1 (
      .aclk(aclk), .areset(areset), .s_axis_tdata(tdata[1]), .s_axis_tstrb(tstrb[1]),
      .s_axis_tuser(tuser[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
      .s_axis_tlast(tlast[1]), .counter(cnt[1]), .activity_rec(act[1]), .pkt_count(pcnt[1]),
      .overflow(ovf[1]), .rec_valid(rvalid[1]), .rec_rd_en(rd_en[1]), .rec_len(rlen[1]),
      .rec_tag(rtag[1]), .rec_err(rerr[1]));

   nf10_axis_pkt_recorder #(.C_REC_DEPTH(2), .C_BP_MODE(2)) u2 (
      .aclk(aclk), .areset(areset), .s_axis_tdata(tdata[2]), .s_axis_tstrb(tstrb[2]),
      .s_axis_tuser(tuser[2]), .s_axis_tvalid(tvalid[2]), .s_axis_tready(tready[2]),
      .s_axis_tlast(tlast[2]), .counter(cnt[2]), .activity_rec(act[2]), .pkt_count(pcnt[2]),
      .overflow(ovf[2]), .rec_valid(rvalid[2]), .rec_rd_en(rd_en[2]), .rec_len(rlen[2]),
      .rec_tag(rtag[2]), .rec_err(rerr[2]));

   // activity pulses of instance 0 since the last reset
   always @(negedge aclk) begin
      if (areset) act_cnt = 0;
      else if (act[0]) act_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 3; k++) begin
         tdata[k] = '0;
         tstrb[k] = '0;
         tuser[k] = '0;
      end
      tvalid = '0;
      tlast  = '0;
      rd_en  = '0;
   endtask

   // Leaves the bench at a negedge one rising edge after reset release
   task automatic do_reset();
      @(negedge aclk);
      areset = 1'b1;
      clear_inputs();
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
   endtask

   // Drive one beat from a negedge and return at the negedge after it is accepted
   task automatic beat(input int k, input logic [31:0] s, input logic [15:0] tg, input logic l);
      int w;
      w = 0;
      tvalid[k] = 1'b1;
      tstrb[k]  = s;
      tuser[k]  = {96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 16'hA5A5, tg};
      tdata[k]  = {8{$urandom()}};
      tlast[k]  = l;
      while (!tready[k] && w < LIM) begin
         @(negedge aclk);
         w++;
      end
      if (w >= LIM) check("accept_timeout", 64'(w), 64'(0));
      @(negedge aclk);
      tvalid[k] = 1'b0;
      tlast[k]  = 1'b0;
   endtask

   task automatic pop(input int k);
      rd_en[k] = 1'b1;
      @(negedge aclk);
      rd_en[k] = 1'b0;
   endtask

   // Two-beat packet on instance 0, then check and pop its record
   task automatic pkt2(input logic [31:0] sa, input logic [31:0] sb, input logic [15:0] tg,
                       input logic [15:0] elen, input logic eerr);
      beat(0, sa, tg, 1'b0);
      beat(0, sb, 16'h7777, 1'b1);
      check("err_len", rlen[0], elen);
      check("err_tag", rtag[0], tg);
      check("err_flag", rerr[0], eerr);
      pop(0);
   endtask

   logic [15:0] m;
   logic        fb;

   initial begin
      clear_inputs();
      repeat (2) @(negedge aclk);
      // reset values while areset is held
      check("rst_tready0", tready[0], 0);
      check("rst_tready1", tready[1], 0);
      check("rst_tready2", tready[2], 0);
      check("rst_counter", cnt[0], 0);
      check("rst_act", act[0], 0);
      check("rst_pkt", pcnt[0], 0);
      check("rst_ovf", ovf[0], 0);
      check("rst_rvalid", rvalid[0], 0);
      check("rst_rec", {rlen[0], rtag[0], rerr[0]}, 0);

      // Mode 0: three 2-beat packets of 32+16 bytes
      do_reset();
      check("t1_tready", tready[0], 1);
      for (int t = 1; t <= 3; t++) begin
         beat(0, 32'hFFFF_FFFF, 16'(t), 1'b0);
         if (t == 1) begin
            check("t1_act_pulse", act[0], 1);
            check("t1_rv_mid", rvalid[0], 0);
         end
         beat(0, 32'h0000_FFFF, 16'hBEEF, 1'b1);
         if (t == 1) check("t1_rv_latency", rvalid[0], 1);
      end
      @(negedge aclk);
      check("t1_act_idle", act[0], 0);
      check("t1_counter", cnt[0], 3);
      for (int t = 1; t <= 3; t++) begin
         check("t1_len", rlen[0], 48);
         check("t1_tag", rtag[0], 64'(t));
         check("t1_err", rerr[0], 0);
         pop(0);
      end
      check("t1_empty", rvalid[0], 0);

      // Mode 0: 18 single-beat packets into depth 16
      do_reset();
      for (int i = 0; i < 18; i++) beat(0, 32'hFFFF_FFFF, 16'(16'h10 + i), 1'b1);
      check("t2_ovf", ovf[0], 1);
      check("t2_pkt", pcnt[0], 18);
      check("t2_counter", cnt[0], 18);
      for (int i = 0; i < 16; i++) begin
         check("t2_tag", rtag[0], 64'(16'h10 + i));
         check("t2_len", rlen[0], 32);
         pop(0);
      end
      check("t2_empty", rvalid[0], 0);

      // Mode 0: push into full FIFO with a pop on the same edge
      do_reset();
      for (int i = 0; i < 16; i++) beat(0, 32'hFFFF_FFFF, 16'(16'h40 + i), 1'b1);
      check("t2b_ovf_pre", ovf[0], 0);
      rd_en[0] = 1'b1;
      beat(0, 32'hFFFF_FFFF, 16'h0050, 1'b1);
      rd_en[0] = 1'b0;
      check("t2b_ovf", ovf[0], 0);
      check("t2b_head", rtag[0], 16'h41);
      for (int i = 0; i < 15; i++) pop(0);
      check("t2b_tail", rtag[0], 16'h50);

      // Mode 0: strobe legality
      do_reset();
      pkt2(32'hFFFF_FFFE, 32'h0000_0005, 16'h0005, 16'd33, 1'b1);
      pkt2(32'hFFFF_FFFF, 32'h0000_0007, 16'h0006, 16'd35, 1'b0);
      pkt2(32'hFFFF_FFFE, 32'h0000_0003, 16'h0008, 16'd33, 1'b1);
      pkt2(32'hFFFF_FFFF, 32'h8000_0000, 16'h0009, 16'd33, 1'b1);
      beat(0, 32'h0000_0000, 16'h000A, 1'b1);
      check("t3_zero_last_err", rerr[0], 1);
      check("t3_zero_last_len", rlen[0], 0);
      pop(0);
      beat(0, 32'hFFFF_FFFF, 16'h000B, 1'b1);
      check("t3_full_last_err", rerr[0], 0);
      pop(0);

      // Mode 2, depth 2: stall on full, resume after a pop
      do_reset();
      beat(2, 32'hFFFF_FFFF, 16'h0001, 1'b1);
      beat(2, 32'hFFFF_FFFF, 16'h0002, 1'b1);
      check("t4_tready_full", tready[2], 0);
      tvalid[2] = 1'b1;
      tstrb[2]  = 32'hFFFF_FFFF;
      tuser[2]  = 128'h3;
      tlast[2]  = 1'b0;
      repeat (4) @(negedge aclk);
      check("t4_stalled", tready[2], 0);
      check("t4_no_accept", act[2], 0);
      check("t4_counter_hold", cnt[2], 2);
      pop(2);
      check("t4_resume", tready[2], 1);
      check("t4_head", rtag[2], 2);
      beat(2, 32'hFFFF_FFFF, 16'h0003, 1'b0);
      beat(2, 32'hFFFF_FFFF, 16'h0009, 1'b1);
      check("t4_counter", cnt[2], 3);
      check("t4_ovf", ovf[2], 0);
      pop(2);
      check("t4_tag3", rtag[2], 3);
      check("t4_len3", rlen[2], 64);
      pop(2);
      check("t4_empty", rvalid[2], 0);

      // Mode 1: tready against x^16+x^14+x^13+x^11+1 reference from the seed
      do_reset();
      m = 16'hACE1;
      for (int c = 0; c < 64; c++) begin
         check("t5_lfsr", tready[1], m[0]);
         fb = m[0] ^ m[2] ^ m[3] ^ m[5];
         m  = {fb, m[15:1]};
         @(negedge aclk);
      end
      beat(1, 32'hFFFF_FFFF, 16'h0007, 1'b1);
      check("t5_cnt_pre", cnt[1], 1);
      check("t5_rv_pre", rvalid[1], 1);
      beat(1, 32'hFFFF_FFFF, 16'h0008, 1'b0);
      areset = 1'b1;
      #1;
      check("t5_rst_tready", tready[1], 0);
      check("t5_rst_cnt", cnt[1], 0);
      check("t5_rst_pkt", pcnt[1], 0);
      check("t5_rst_act", act[1], 0);
      check("t5_rst_ovf", ovf[1], 0);
      check("t5_rst_rv", rvalid[1], 0);
      check("t5_rst_rec", {rlen[1], rtag[1], rerr[1]}, 0);
      @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      beat(1, 32'h0000_000F, 16'h0009, 1'b1);
      check("t5_len_after", rlen[1], 4);
      check("t5_tag_after", rtag[1], 9);
      check("t5_err_after", rerr[1], 0);

      // Mode 0: counter wrap over 260 packets
      do_reset();
      for (int i = 0; i < 260; i++) beat(0, 32'hFFFF_FFFF, 16'(i), 1'b1);
      @(negedge aclk);
      check("t6_counter_wrap", cnt[0], 4);
      check("t6_pkt", pcnt[0], 260);
      check("t6_act_pulses", 64'(act_cnt), 260);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nf10_axis_pkt_recorder.md
# nf10_axis_pkt_recorder

Parametrised AXI4-Stream packet sink and recorder for the NetFPGA-10G simulation and bring-up fabric. It terminates one slave stream and can apply configurable backpressure. It counts beats and packets, checks strobe legality, and captures a per-packet summary (byte length, tuser tag, error flag) into an on-chip record FIFO that a testbench or register block drains. It is synthesizable and sits wherever a sim-only recorder would otherwise terminate a stream.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, tdata width; multiple of 8, at most 256.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width; at least 16.
- C_REC_DEPTH, 16, record FIFO entries; power of 2, at least 2.
- C_BP_MODE, 0, tready policy: 0 always ready, 1 LFSR pseudo-random, 2 stall when record FIFO full.
- C_LFSR_SEED, 16'hACE1, non-zero 16-bit seed for mode 1.

Ports:
- aclk  in  1  clock.
- areset  in  1  reset; asynchronous, active-high.
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  stream data; ignored except for the handshake.
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte strobes.
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  sideband; bits [15:0] are sampled on the first beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat ready.
- s_axis_tlast  in  1  last beat of packet.
- counter  out  8  completed packets, mod 256.
- activity_rec  out  1  one-cycle pulse after each accepted beat.
- pkt_count  out  32  completed packets, saturating.
- overflow  out  1  sticky; a record was dropped.
- rec_valid  out  1  record FIFO non-empty.
- rec_rd_en  in  1  pop the head record; ignored when empty.
- rec_len  out  16  head record byte length.
- rec_tag  out  16  head record tuser[15:0].
- rec_err  out  1  head record strobe error.

## Operation
- A beat is accepted when s_axis_tvalid and s_axis_tready are both high at a rising edge of aclk.
- FSM states:
  - IDLE to IN_PKT on an accepted beat with tlast=0.
  - IDLE stays in IDLE on an accepted beat with tlast=1 (single-beat packet).
  - IN_PKT to IDLE on an accepted beat with tlast=1.
- First beat (accepted in IDLE): latch tuser[15:0] into the tag. Load the length accumulator with popcount(tstrb) and clear the error flag.
- Later beats: add popcount(tstrb) to the length. The sum saturates at 16'hFFFF.
- Strobe error on a non-last beat: tstrb is not all-ones.
- Strobe error on a last beat: tstrb is zero, or is not contiguous from bit 0 (not of the form 0..01..1).
- Errors are ORed across the packet.
- On the tlast beat, push {len, tag, err} into the FIFO. On the same edge:
  - counter increments and wraps 255 to 0.
  - pkt_count increments and holds at 32'hFFFF_FFFF.
- FIFO full at a push, modes 0 and 1: drop the record, set overflow. counter and pkt_count still increment.
- FIFO full at a push with rec_rd_en high in the same cycle: the push succeeds and no drop occurs.
- tready by mode:
  - Mode 0: constant 1 out of reset.
  - Mode 1: registered LFSR bit 0. The LFSR is 16-bit Fibonacci x^16+x^14+x^13+x^11+1 and advances every cycle.
  - Mode 2: tready = !full. An in-flight packet stalls until a pop, and no record is ever dropped.

## Timing
- Reset values:
  - s_axis_tready 0, counter 0, activity_rec 0, pkt_count 0, overflow 0, rec_valid 0.
  - rec_len, rec_tag and rec_err are 0.
  - LFSR loads C_LFSR_SEED and the FSM goes to IDLE.
- Reset asserted mid-packet discards the partial packet. FIFO contents are lost.
- tready first rises in the first cycle after areset deasserts. In mode 1 it follows the seed.
- activity_rec is high in the cycle after each accepted beat.
- Record latency: rec_valid rises 1 cycle after the tlast beat is accepted. The FIFO is first-word fall-through, so the head fields are valid whenever rec_valid is high.
- Pop: the next entry appears 1 cycle after the rec_rd_en edge.
- tready does not depend combinationally on tvalid in any mode.

## Structure
- Package nf10_axis_rec_pkg holds:
  - mode constants BP_ALWAYS, BP_LFSR, BP_FULL;
  - the record field widths and the record packing order {err, tag, len}, 33 bits;
  - the LFSR tap mask.
- Sub-module nf10_axis_rec_fifo: a synchronous FWFT FIFO, width 33, depth C_REC_DEPTH, with full, empty, and simultaneous push/pop.
- The top level holds the FSM, the accumulator, the strobe checker (popcount and contiguity function), the counters and the tready logic.

## Test plan
- Mode 0, three 2-beat packets with tstrb all-ones then 32'h0000_FFFF, tags 1/2/3: three records, each len 48, err 0, tags 1/2/3 in order; counter=3.
- Mode 0, 18 single-beat packets, no pops, depth 16: 16 records, overflow=1, pkt_count=18. Popping all entries returns the first 16 tags.
- Mode 0, non-last beat tstrb 32'hFFFF_FFFE, then last beat 32'h0000_0005: one record with err=1. A later clean packet gives err=0.
- Mode 2, depth 2, no pops: tready drops after the 2nd record and the 3rd packet stalls. One pop resumes it, and the 3rd record is stored with overflow=0.
- Mode 1: observe tready for 64 cycles and match it against a reference LFSR model from the seed. Assert areset mid-packet: all outputs return to their reset values, and the next packet records its length correctly.
- 260 single-beat packets: counter=4 (wrapped), pkt_count=260; activity_rec pulses 260 times.
